// File: rtl/game_timer_ctrl.sv
// Countdown timer sequencer for the game round.
// Owns the seconds time base (a per-period down-counter), a 0..99 second count
// and the game-phase FSM (IDLE / RUN / PAUSED / DONE).
//
// Ports:
//   ClockIn   - system clock
//   Reset     - synchronous, active-high
//   Start     - one-cycle pulse; starts or restarts a round
//   Pause     - level; 1 freezes the timer
//   Bonus     - one-cycle pulse; adds BONUS_SECONDS (saturating at 99)
//   Speed     - time-base select, period D = CLOCK_FREQUENCY >> Speed
//   TensValue - BCD tens digit of the count (combinational from the count flop)
//   OnesValue - BCD ones digit of the count (combinational from the count flop)
//   State     - 00 IDLE, 01 RUN, 10 PAUSED, 11 DONE
//   Tick      - one-cycle pulse in the cycle the count first shows a decrement
//   TimeUp    - one-cycle pulse on entry to DONE
module game_timer_ctrl #(
  parameter int unsigned CLOCK_FREQUENCY = 50000000,
  parameter int unsigned GAME_SECONDS    = 60,
  parameter int unsigned BONUS_SECONDS   = 5
) (
  input  logic       ClockIn,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Pause,
  input  logic       Bonus,
  input  logic [1:0] Speed,
  output logic [3:0] TensValue,
  output logic [3:0] OnesValue,
  output logic [1:0] State,
  output logic       Tick,
  output logic       TimeUp
);

  localparam int unsigned DIV_W = (CLOCK_FREQUENCY > 1) ? $clog2(CLOCK_FREQUENCY) : 1;
  localparam int unsigned CNT_W = 7;
  localparam int unsigned SUM_W = 8;

  localparam logic [CNT_W-1:0] COUNT_MAX  = 7'd99;
  localparam logic [CNT_W-1:0] GAME_COUNT = CNT_W'(GAME_SECONDS);
  localparam logic [SUM_W-1:0] BONUS_ADD  = SUM_W'(BONUS_SECONDS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

  state_t           state_q,   state_d;
  logic [CNT_W-1:0] count_q,   count_d;
  logic [DIV_W-1:0] div_q,     div_d;
  logic             tick_q,    tick_d;
  logic             time_up_q, time_up_d;

  logic [31:0]      period;
  logic [DIV_W-1:0] reload;
  logic             expire;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] next_count;

  // Divider reload value D-1 for the currently selected speed; D never below 1.
  always_comb begin
    period = 32'(CLOCK_FREQUENCY) >> Speed;
    if (period == 32'd0) begin
      period = 32'd1;
    end
    reload = DIV_W'(period - 32'd1);
  end

  // Count update for tick and/or bonus; the sum is one bit wider so the
  // saturation to 99 sees the true value.
  always_comb begin
    expire = (state_q == ST_RUN) && !Pause && (div_q == '0);
    sum    = SUM_W'(count_q);
    if (Bonus) begin
      sum = sum + BONUS_ADD;
    end
    if (expire && (count_q != '0)) begin
      sum = sum - 8'd1;
    end
    next_count = (sum > SUM_W'(COUNT_MAX)) ? COUNT_MAX : CNT_W'(sum);
  end

  // Next-state and register-input logic.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    div_d     = div_q;
    tick_d    = 1'b0;
    time_up_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_RUN;
          count_d = GAME_COUNT;
          div_d   = reload;
        end
      end

      ST_RUN: begin
        if (Start) begin
          count_d = GAME_COUNT;
          div_d   = reload;
        end else begin
          count_d = next_count;
          if (expire) begin
            div_d  = reload;
            tick_d = 1'b1;
          end else if (!Pause) begin
            div_d = div_q - DIV_W'(1);
          end
          // A bonus landing with the last tick keeps the round alive.
          if (expire && (next_count == '0)) begin
            state_d   = ST_DONE;
            time_up_d = 1'b1;
          end else if (Pause) begin
            state_d = ST_PAUSED;
          end
        end
      end

      ST_PAUSED: begin
        if (Start) begin
          state_d = ST_RUN;
          count_d = GAME_COUNT;
          div_d   = reload;
        end else begin
          // Divider holds so a resume continues mid-period.
          count_d = next_count;
          if (!Pause) begin
            state_d = ST_RUN;
          end
        end
      end

      ST_DONE: begin
        if (Start) begin
          state_d = ST_RUN;
          count_d = GAME_COUNT;
          div_d   = reload;
        end
      end

      default: begin
        state_d = ST_IDLE;
        count_d = GAME_COUNT;
        div_d   = reload;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      count_q   <= GAME_COUNT;
      div_q     <= reload;
      tick_q    <= 1'b0;
      time_up_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      div_q     <= div_d;
      tick_q    <= tick_d;
      time_up_q <= time_up_d;
    end
  end

  // BCD digits straight off the count register.
  assign TensValue = 4'(count_q / 7'd10);
  assign OnesValue = 4'(count_q % 7'd10);

  assign State  = state_q;
  assign Tick   = tick_q;
  assign TimeUp = time_up_q;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Self-checking bench for game_timer_ctrl with CLOCK_FREQUENCY=8,
// GAME_SECONDS=3, BONUS_SECONDS=5: directed scenarios with literal
// expectations, then randomized stimulus against a behavioural model.
module tb_game_timer_ctrl;

  localparam int unsigned CF = 8;
  localparam int unsigned GS = 3;
  localparam int unsigned BS = 5;

  logic       ClockIn = 1'b0;
  logic       Reset, Start, Pause, Bonus;
  logic [1:0] Speed;
  logic [3:0] TensValue, OnesValue;
  logic [1:0] State;
  logic       Tick, TimeUp;

  game_timer_ctrl #(
    .CLOCK_FREQUENCY(CF),
    .GAME_SECONDS   (GS),
    .BONUS_SECONDS  (BS)
  ) dut (
    .ClockIn  (ClockIn),
    .Reset    (Reset),
    .Start    (Start),
    .Pause    (Pause),
    .Bonus    (Bonus),
    .Speed    (Speed),
    .TensValue(TensValue),
    .OnesValue(OnesValue),
    .State    (State),
    .Tick     (Tick),
    .TimeUp   (TimeUp)
  );

  always #5 ClockIn = ~ClockIn;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model: phase 0 idle, 1 run, 2 paused, 3 done; a period is tracked as
  // cycles elapsed out of its length in cycles.
  int m_state   = 0;
  int m_count   = 0;
  int m_elapsed = 0;
  int m_period  = 1;
  int m_tick    = 0;
  int m_tu      = 0;

  function automatic int period_of(input logic [1:0] s);
    int d;
    d = int'(CF >> s);
    if (d < 1) d = 1;
    return d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge ClockIn);
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    step();
    Start = 1'b0;
  endtask

  task automatic restart_round();
    m_state   = 1;
    m_count   = GS;
    m_elapsed = 0;
    m_period  = period_of(Speed);
  endtask

  // Behavioural reference, advanced on each active edge.
  always @(posedge ClockIn) begin
    int tk;
    int newc;
    m_tick = 0;
    m_tu   = 0;
    if (Reset) begin
      m_state   = 0;
      m_count   = GS;
      m_elapsed = 0;
      m_period  = period_of(Speed);
    end else if (Start) begin
      restart_round();
    end else begin
      case (m_state)
        1: begin
          tk = (!Pause && (m_elapsed == m_period - 1)) ? 1 : 0;
          if (tk == 1) begin
            m_tick    = 1;
            m_elapsed = 0;
            m_period  = period_of(Speed);
          end else if (!Pause) begin
            m_elapsed++;
          end
          newc = m_count - tk + (Bonus ? int'(BS) : 0);
          if (newc > 99) newc = 99;
          m_count = newc;
          if (tk == 1 && newc == 0) begin
            m_state = 3;
            m_tu    = 1;
          end else if (Pause) begin
            m_state = 2;
          end
        end
        2: begin
          if (Bonus) m_count = (m_count + int'(BS) > 99) ? 99 : m_count + int'(BS);
          if (!Pause) m_state = 1;
        end
        default: ;
      endcase
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge ClockIn) begin
    if (chk_en) begin
      chk("model_state",  32'(State),     32'(m_state));
      chk("model_tens",   32'(TensValue), 32'(m_count / 10));
      chk("model_ones",   32'(OnesValue), 32'(m_count % 10));
      chk("model_tick",   32'(Tick),      32'(m_tick));
      chk("model_timeup", 32'(TimeUp),    32'(m_tu));
    end
  end

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    Pause = 1'b0;
    Bonus = 1'b0;
    Speed = 2'b00;
    step();
    step();
    chk_en = 1'b1;
    chk("rst_state", 32'(State), 0);
    chk("rst_tens", 32'(TensValue), 0);
    chk("rst_ones", 32'(OnesValue), 3);
    chk("rst_tick", 32'(Tick), 0);
    chk("rst_timeup", 32'(TimeUp), 0);
    Reset = 1'b0;
    step();

    // Full round at Speed=00.
    pulse_start();
    chk("start_state", 32'(State), 1);
    chk("start_ones", 32'(OnesValue), 3);
    for (int k = 1; k <= 24; k++) begin
      step();
      if (k == 7)  chk("pre_tick", 32'(Tick), 0);
      if (k == 8)  begin chk("c8_ones", 32'(OnesValue), 2); chk("c8_tick", 32'(Tick), 1); end
      if (k == 16) begin chk("c16_ones", 32'(OnesValue), 1); chk("c16_tick", 32'(Tick), 1); end
      if (k == 24) begin
        chk("c24_ones", 32'(OnesValue), 0);
        chk("c24_tick", 32'(Tick), 1);
        chk("c24_timeup", 32'(TimeUp), 1);
        chk("c24_state", 32'(State), 3);
      end
    end
    step();
    chk("done_hold_ones", 32'(OnesValue), 0);
    chk("done_timeup_gone", 32'(TimeUp), 0);

    // Start in DONE reloads with a full first period.
    pulse_start();
    chk("done_restart_state", 32'(State), 1);
    repeat (7) step();
    chk("done_restart_c7", 32'(OnesValue), 3);
    step();
    chk("done_restart_c8", 32'(OnesValue), 2);

    // Start mid-RUN.
    repeat (3) step();
    pulse_start();
    chk("mid_restart_ones", 32'(OnesValue), 3);
    repeat (7) step();
    chk("mid_restart_c7", 32'(OnesValue), 3);
    step();
    chk("mid_restart_c8", 32'(OnesValue), 2);

    // Speed=11: decrement every cycle.
    Speed = 2'b11;
    pulse_start();
    chk("fast_c0", 32'(OnesValue), 3);
    step(); chk("fast_c1", 32'(OnesValue), 2);
    step(); chk("fast_c2", 32'(OnesValue), 1);
    step(); chk("fast_c3", 32'(OnesValue), 0);
    chk("fast_done", 32'(State), 3);
    chk("fast_timeup", 32'(TimeUp), 1);

    // Pause mid-period, then resume.
    Speed = 2'b00;
    pulse_start();
    repeat (5) step();
    Pause = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("paused_state", 32'(State), 2);
      chk("paused_ones", 32'(OnesValue), 3);
    end
    Pause = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("resume_state", 32'(State), 1);
      chk("resume_ones", 32'(OnesValue), 3);
    end
    step();
    chk("resume_tick_ones", 32'(OnesValue), 2);
    chk("resume_tick", 32'(Tick), 1);

    // Start with Pause held: RUN, then PAUSED; then bonus to saturation.
    Pause = 1'b1;
    pulse_start();
    chk("start_paused_run", 32'(State), 1);
    step();
    chk("start_paused_pause", 32'(State), 2);
    Bonus = 1'b1;
    repeat (19) step();
    Bonus = 1'b0;
    chk("bonus98_tens", 32'(TensValue), 9);
    chk("bonus98_ones", 32'(OnesValue), 8);
    Bonus = 1'b1;
    step();
    chk("bonus99_ones", 32'(OnesValue), 9);
    step();
    Bonus = 1'b0;
    chk("bonus_sat_tens", 32'(TensValue), 9);
    chk("bonus_sat_ones", 32'(OnesValue), 9);

    // Bonus coincident with the last tick.
    Pause = 1'b0;
    Speed = 2'b11;
    pulse_start();
    step();
    step();
    chk("pre_bonus_one", 32'(OnesValue), 1);
    Bonus = 1'b1;
    step();
    Bonus = 1'b0;
    chk("bonus_tick_ones", 32'(OnesValue), 5);
    chk("bonus_tick_state", 32'(State), 1);
    chk("bonus_tick_tick", 32'(Tick), 1);
    chk("bonus_tick_timeup", 32'(TimeUp), 0);

    // Reset mid-RUN with the divider at 4.
    Speed = 2'b00;
    pulse_start();
    repeat (3) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("midrst_state", 32'(State), 0);
    chk("midrst_tens", 32'(TensValue), 0);
    chk("midrst_ones", 32'(OnesValue), 3);
    chk("midrst_tick", 32'(Tick), 0);
    chk("midrst_timeup", 32'(TimeUp), 0);
    pulse_start();
    repeat (7) step();
    chk("postrst_c7", 32'(OnesValue), 3);
    step();
    chk("postrst_c8", 32'(OnesValue), 2);

    // Randomized stimulus, checked every cycle by the model compare.
    for (int i = 0; i < 4000; i++) begin
      Start = ($urandom_range(0, 99) < 3);
      Bonus = ($urandom_range(0, 99) < 6);
      if ($urandom_range(0, 99) < 4) Pause = ~Pause;
      if ($urandom_range(0, 99) < 2) Speed = 2'($urandom_range(0, 3));
      Reset = ($urandom_range(0, 999) < 3);
      step();
    end
    Start = 1'b0;
    Bonus = 1'b0;
    Reset = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
